dp_framer: RTL and testbench

DP_FRAMER -- requirements
Module: dp_framer

---
 rtl/dp_pkg.sv | 28 ++
 rtl/dp_timing.sv | 47 ++++
 rtl/dp_framer.sv | 134 +++++++++++++
 tb/tb_dp_framer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the DisplayPort-style framer: K-code symbols, framer
// state enum and the colour-bar table used by the optional test pattern.
package dp_pkg;

    localparam logic [7:0] K_BE = 8'hFB;
    localparam logic [7:0] K_BS = 8'hBC;

    typedef enum logic [2:0] {
        ST_BE,
        ST_DATA,
        ST_BS,
        ST_VBID,
        ST_MVID,
        ST_MAUD,
        ST_DUMMY
    } dp_state_e;

    // {R, G, B}: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_COLOUR [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic logic [31:0] lanes4(input logic [7:0] b);
        return {4{b}};
    endfunction

endpackage

// File: rtl/dp_timing.sv
// Raster position generator for dp_framer: column hx and line ly counters,
// plus vertical-blank and start-of-line flags.
module dp_timing #(
    parameter int HTOTAL  = 600,
    parameter int VTOTAL  = 500,
    parameter int VACTIVE = 480,
    parameter int HW      = 10,
    parameter int VW      = 9
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] hx,
    output logic [VW-1:0] ly,
    output logic          vblank,
    output logic          line_start
);

    logic [HW-1:0] hx_q, hx_d;
    logic [VW-1:0] ly_q, ly_d;

    always_comb begin
        hx_d = hx_q + 1'b1;
        ly_d = ly_q;
        if (hx_q == HW'(HTOTAL - 1)) begin
            hx_d = '0;
            ly_d = (ly_q == VW'(VTOTAL - 1)) ? '0 : ly_q + 1'b1;
        end
    end

    // Reset parks the raster at the first blank line so the converter gets a
    // full vertical blank to resynchronise before line 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            hx_q <= '0;
            ly_q <= VW'(VACTIVE);
        end else begin
            hx_q <= hx_d;
            ly_q <= ly_d;
        end
    end

    assign hx         = hx_q;
    assign ly         = ly_q;
    assign vblank     = (ly_q >= VW'(VACTIVE));
    assign line_start = (hx_q == '0);

endmodule

// File: rtl/dp_framer.sv
// Four-lane main-link framer: inserts BE/BS/VB-ID/Mvid/Maud around payload words.
// Optional colour-bar generator enabled by defining DP_TESTPAT_EN (adds port tpat).
//
// state    | meaning
// ST_BE    | blank-end K-code, column 0 of an active line
// ST_DATA  | payload word from the converter (or colour bar)
// ST_BS    | blank-start K-code
// ST_VBID  | VB-ID byte, bit0 = vertical blank
// ST_MVID  | Mvid[7:0] byte
// ST_MAUD  | Maud byte (no audio, zero)
// ST_DUMMY | fill symbols
module dp_framer
    import dp_pkg::*;
#(
    parameter int          HACTIVE = 480,
    parameter int          VACTIVE = 480,
    parameter int          HTOTAL  = 600,
    parameter int          VTOTAL  = 500,
    parameter logic [7:0]  MVID    = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] indat,
`ifdef DP_TESTPAT_EN
    input  logic        tpat,
`endif
    output logic        consume,
    output logic        restart,
    output logic [31:0] sym,
    output logic [3:0]  k
);

    localparam int HW = $clog2(HTOTAL);
    localparam int VW = $clog2(VTOTAL);

    logic [HW-1:0] hx;
    logic [VW-1:0] ly;
    logic          vblank;
    logic          line_start;
    logic          tpat_on;
    logic [2:0]    bar;
    dp_state_e     cur_state;
    logic [31:0]   sym_q, sym_d;
    logic [3:0]    k_q, k_d;

    dp_timing #(
        .HTOTAL (HTOTAL),
        .VTOTAL (VTOTAL),
        .VACTIVE(VACTIVE),
        .HW     (HW),
        .VW     (VW)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .hx        (hx),
        .ly        (ly),
        .vblank    (vblank),
        .line_start(line_start)
    );

`ifdef DP_TESTPAT_EN
    assign tpat_on = tpat;
`else
    assign tpat_on = 1'b0;
`endif

    // Each bar spans 64 payload words, counted from the first DATA column.
    assign bar = 3'((16'(hx) - 16'd1) >> 6);

    // The secondary-data columns sit at the same place on every line; only
    // active lines carry BE and payload.
    always_comb begin
        cur_state = ST_DUMMY;
        if (hx == HW'(HACTIVE + 1)) begin
            cur_state = ST_BS;
        end else if (hx == HW'(HACTIVE + 2)) begin
            cur_state = ST_VBID;
        end else if (hx == HW'(HACTIVE + 3)) begin
            cur_state = ST_MVID;
        end else if (hx == HW'(HACTIVE + 4)) begin
            cur_state = ST_MAUD;
        end else if (!vblank) begin
            if (line_start) begin
                cur_state = ST_BE;
            end else if (hx <= HW'(HACTIVE)) begin
                cur_state = ST_DATA;
            end
        end
    end

    always_comb begin
        sym_d = '0;
        k_d   = '0;
        unique case (cur_state)
            ST_BE: begin
                sym_d = lanes4(K_BE);
                k_d   = 4'hF;
            end
            ST_DATA: begin
                sym_d = tpat_on ? {BAR_COLOUR[bar], 8'h00} : indat;
            end
            ST_BS: begin
                sym_d = lanes4(K_BS);
                k_d   = 4'hF;
            end
            ST_VBID: begin
                sym_d = lanes4({7'b0, vblank});
            end
            ST_MVID: begin
                sym_d = lanes4(MVID);
            end
            default: begin
            end
        endcase
    end

    // Reset clears the symbol pipeline outright, so an interrupted line is
    // simply dropped rather than closed with BS/BE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_q <= '0;
            k_q   <= '0;
        end else begin
            sym_q <= sym_d;
            k_q   <= k_d;
        end
    end

    assign consume = !rst && (cur_state == ST_DATA) && !tpat_on;
    assign restart = !rst && line_start && (ly == VW'(VACTIVE));
    assign sym     = sym_q;
    assign k       = k_q;

endmodule

// File: tb/tb_dp_framer.sv
// Bench for dp_framer: a default-timing instance for positional checks and a
// small-raster instance under random data and random resets, both scored by a raster model.
`timescale 1ns/1ps
module tb_dp_framer;

    localparam int A_HA = 480, A_VA = 480, A_HT = 600, A_VT = 500;
    localparam logic [7:0] A_MV = 8'h5A;
    localparam int B_HA = 8, B_VA = 4, B_HT = 16, B_VT = 6;
    localparam logic [7:0] B_MV = 8'h00;
`ifdef DP_TESTPAT_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif
    localparam logic [23:0] COL [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    typedef struct {
        int          ln;
        int          col;
        logic [31:0] sym;
        logic [3:0]  k;
        logic        cons;
        logic        rs;
        int          wc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, tpat_a, tpat_b;
    logic [31:0] indat_a, indat_b, sym_a, sym_b;
    logic [3:0]  k_a, k_b;
    logic        consume_a, consume_b, restart_a, restart_b;

    int n_cmp = 0, n_bad = 0;
    int n_a = 0, n_b = 0, wcnt_a = 0, fcnt_b = 0;
    bit fvalid_b = 1'b0, rand_b = 1'b0;
    logic [31:0] es_a = '0, es_b = '0;
    logic [3:0]  ek_a = '0, ek_b = '0;

    dp_framer #(.MVID(A_MV)) u_a (
        .clk    (clk),
        .rst    (rst_a),
        .indat  (indat_a),
`ifdef DP_TESTPAT_EN
        .tpat   (tpat_a),
`endif
        .consume(consume_a),
        .restart(restart_a),
        .sym    (sym_a),
        .k      (k_a)
    );

    dp_framer #(.HACTIVE(B_HA), .VACTIVE(B_VA), .HTOTAL(B_HT), .VTOTAL(B_VT), .MVID(B_MV)) u_b (
        .clk    (clk),
        .rst    (rst_b),
        .indat  (indat_b),
`ifdef DP_TESTPAT_EN
        .tpat   (tpat_b),
`endif
        .consume(consume_b),
        .restart(restart_b),
        .sym    (sym_b),
        .k      (k_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Symbol a raster position should produce, straight from the framing rules.
    function automatic void ref_out(input int ha, input int va, input logic [7:0] mv,
                                    input int hx, input int ly, input logic [31:0] din,
                                    input logic tp, output logic [31:0] s,
                                    output logic [3:0] kk, output logic cons);
        s = '0;
        kk = '0;
        cons = 1'b0;
        if (ly < va && hx == 0) begin
            s = {4{8'hFB}};
            kk = 4'hF;
        end else if (ly < va && hx <= ha) begin
            cons = !tp;
            s = tp ? {COL[((hx - 1) / 64) % 8], 8'h00} : din;
        end else if (hx == ha + 1) begin
            s = {4{8'hBC}};
            kk = 4'hF;
        end else if (hx == ha + 2) begin
            s = {4{7'b0, (ly >= va)}};
        end else if (hx == ha + 3) begin
            s = {4{mv}};
        end
    endfunction

    task automatic model_chk(input string tag, input int ha, input int va, input int ht,
                             input int vt, input logic [7:0] mv, input int n, input logic r,
                             input logic [31:0] din, input logic tp, input logic cons_act,
                             input logic rs_act, input logic [31:0] sym_act,
                             input logic [3:0] k_act, input logic [31:0] es,
                             input logic [3:0] ek, output logic [31:0] ns,
                             output logic [3:0] nk, output logic erst);
        int hx, ly;
        logic c;
        hx = n % ht;
        ly = (va + n / ht) % vt;
        ref_out(ha, va, mv, hx, ly, din, tp, ns, nk, c);
        if (r) begin
            c = 1'b0;
            ns = '0;
            nk = '0;
        end
        erst = !r && hx == 0 && ly == va;
        check({tag, " consume"}, 32'(cons_act), 32'(c));
        check({tag, " restart"}, 32'(rs_act), 32'(erst));
        check({tag, " sym"}, sym_act, es);
        check({tag, " k"}, 32'(k_act), 32'(ek));
    endtask

    // One clock: score both DUTs mid-cycle, then advance models and inputs after the edge.
    task automatic cyc();
        logic [31:0] ns_a, ns_b;
        logic [3:0]  nk_a, nk_b;
        logic        er_a, er_b, c_a;
        @(negedge clk);
        model_chk("a", A_HA, A_VA, A_HT, A_VT, A_MV, n_a, rst_a, indat_a, tpat_a,
                  consume_a, restart_a, sym_a, k_a, es_a, ek_a, ns_a, nk_a, er_a);
        model_chk("b", B_HA, B_VA, B_HT, B_VT, B_MV, n_b, rst_b, indat_b, tpat_b,
                  consume_b, restart_b, sym_b, k_b, es_b, ek_b, ns_b, nk_b, er_b);
        c_a = consume_a;
        if (rst_b) begin
            fvalid_b = 1'b0;
            fcnt_b = 0;
        end else if (er_b) begin
            if (fvalid_b) check("b frame consumes", 32'(fcnt_b), 32'(B_HA * B_VA));
            fvalid_b = 1'b1;
            fcnt_b = 0;
        end else if (consume_b) begin
            fcnt_b++;
        end
        @(posedge clk);
        #1;
        es_a = ns_a;
        ek_a = nk_a;
        es_b = ns_b;
        ek_b = nk_b;
        if (rst_a || er_a) wcnt_a = 0;
        else if (c_a) wcnt_a++;
        n_a = rst_a ? 0 : n_a + 1;
        n_b = rst_b ? 0 : n_b + 1;
        indat_a = wcnt_a;
        indat_b = $urandom;
        tpat_a = TP && (((A_VA + n_a / A_HT) % A_VT) == 1);
        if (rand_b) begin
            if (rst_b) rst_b = ($urandom_range(0, 2) != 0);
            else       rst_b = ($urandom_range(0, 1999) == 0);
        end
    endtask

    task automatic run_to_a(input int tgt);
        int guard;
        guard = 0;
        while (n_a < tgt && guard < 40000) begin
            cyc();
            guard++;
        end
        check("a reach position", 32'(n_a), 32'(tgt));
    endtask

    initial begin
        vec_t tv[$];
        int   tgt;
        rst_a = 1'b1;
        rst_b = 1'b1;
        indat_a = '0;
        indat_b = '0;
        tpat_a = 1'b0;
        tpat_b = 1'b0;
        repeat (3) cyc();
        #2;
        check("a reset sym", sym_a, 32'h0);
        check("a reset k", 32'(k_a), 32'h0);
        check("a reset consume", 32'(consume_a), 32'h0);
        check("a reset restart", 32'(restart_a), 32'h0);
        cyc();
        rst_a = 1'b0;
        rst_b = 1'b0;
        rand_b = 1'b1;

        // {line, column, sym, k, consume, restart, line-0 word count or -1}
        tv.push_back('{480, 0,   32'h00000000, 4'h0, 1'b0, 1'b1, -1});
        tv.push_back('{480, 1,   32'h00000000, 4'h0, 1'b0, 1'b0, -1});
        tv.push_back('{480, 482, 32'hBCBCBCBC, 4'hF, 1'b0, 1'b0, -1});
        tv.push_back('{480, 483, 32'h01010101, 4'h0, 1'b0, 1'b0, -1});
        tv.push_back('{480, 484, 32'h5A5A5A5A, 4'h0, 1'b0, 1'b0, -1});
        tv.push_back('{480, 485, 32'h00000000, 4'h0, 1'b0, 1'b0, -1});
        tv.push_back('{499, 482, 32'hBCBCBCBC, 4'hF, 1'b0, 1'b0, -1});
        tv.push_back('{499, 483, 32'h01010101, 4'h0, 1'b0, 1'b0, -1});
        tv.push_back('{0,   1,   32'hFBFBFBFB, 4'hF, 1'b1, 1'b0, -1});
        tv.push_back('{0,   2,   32'h00000000, 4'h0, 1'b1, 1'b0, -1});
        tv.push_back('{0,   3,   32'h00000001, 4'h0, 1'b1, 1'b0, -1});
        tv.push_back('{0,   481, 32'h000001DF, 4'h0, 1'b0, 1'b0, -1});
        tv.push_back('{0,   482, 32'hBCBCBCBC, 4'hF, 1'b0, 1'b0, -1});
        tv.push_back('{0,   483, 32'h00000000, 4'h0, 1'b0, 1'b0, -1});
        tv.push_back('{0,   484, 32'h5A5A5A5A, 4'h0, 1'b0, 1'b0, -1});
        tv.push_back('{1,   0,   32'h00000000, 4'h0, 1'b0, 1'b0, 480});
        tv.push_back('{1,   2,   TP ? 32'hFFFFFF00 : 32'h000001E0, 4'h0, !TP, 1'b0, -1});
        tv.push_back('{1,   65,  TP ? 32'hFFFFFF00 : 32'h0000021F, 4'h0, !TP, 1'b0, -1});
        tv.push_back('{1,   66,  TP ? 32'hFFFF0000 : 32'h00000220, 4'h0, !TP, 1'b0, -1});

        for (int i = 0; i < tv.size(); i++) begin
            tgt = ((tv[i].ln - A_VA + A_VT) % A_VT) * A_HT + tv[i].col;
            run_to_a(tgt);
            #2;
            check($sformatf("a sym L%0d C%0d", tv[i].ln, tv[i].col), sym_a, tv[i].sym);
            check($sformatf("a k L%0d C%0d", tv[i].ln, tv[i].col), 32'(k_a), 32'(tv[i].k));
            check($sformatf("a consume L%0d C%0d", tv[i].ln, tv[i].col),
                  32'(consume_a), 32'(tv[i].cons));
            check($sformatf("a restart L%0d C%0d", tv[i].ln, tv[i].col),
                  32'(restart_a), 32'(tv[i].rs));
            if (tv[i].wc >= 0) check("a line0 consumes", 32'(wcnt_a), 32'(tv[i].wc));
        end

        // Reset in the middle of payload on line 10.
        run_to_a(20 * A_HT + 10 * A_HT + 200);
        rst_a = 1'b1;
        #2;
        check("a rst cycle consume", 32'(consume_a), 32'h0);
        check("a rst cycle restart", 32'(restart_a), 32'h0);
        cyc();
        #2;
        check("a after rst sym", sym_a, 32'h0);
        check("a after rst k", 32'(k_a), 32'h0);
        check("a after rst consume", 32'(consume_a), 32'h0);
        cyc();
        cyc();
        rst_a = 1'b0;
        #2;
        check("a release restart", 32'(restart_a), 32'h1);
        cyc();
        #2;
        check("a post release restart", 32'(restart_a), 32'h0);
        check("a post release sym", sym_a, 32'h0);
        repeat (600) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
